dpr_copier: RTL

//  Initiator-side engine for one port of an 8-bit synchronous RAM (1-cycle registered read).

---
 rtl/dpr_pkg.sv | 12 +
 rtl/dpr_addr_step.sv | 29 ++
 rtl/dpr_copier.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dpr_pkg.sv
// Shared types for the dpr_copier block: FSM state encoding and RAM data width.
package dpr_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

endpackage

// File: rtl/dpr_addr_step.sv
// Loadable AW+1 bit address counter; increments wrap naturally modulo 2**(AW+1).
module dpr_addr_step
  import dpr_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [AW:0] i_loadVal,
  input  logic        i_inc,
  output logic [AW:0] o_value
);

  logic [AW:0] r_value;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_loadVal;
    end else if (i_inc) begin
      r_value <= r_value + {{AW{1'b0}}, 1'b1};
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/dpr_copier.sv
// Single-port RAM block copier (forward, byte by byte, start/busy/done handshake).
// Optional fill mode is enabled by defining DPR_COPIER_FILL_EN.
module dpr_copier
  import dpr_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [AW:0]   src,
  input  logic [AW:0]   dst,
  input  logic [AW:0]   len,
`ifdef DPR_COPIER_FILL_EN
  input  logic          fill,
  input  logic [DW-1:0] pattern,
`endif
  output logic          busy,
  output logic          done,
  output logic          ram_we,
  output logic [AW:0]   ram_a,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q
);

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  state_t      r_state, w_stateNext;
  logic        r_busy, w_busyNext;
  logic        r_done, w_doneNext;
  logic        r_we, w_weNext;
  logic [AW:0] r_a, w_aNext;
  logic [AW:0] r_left, w_leftNext;
  logic        r_fill, w_fillNext;
  logic        w_fillReq;
  logic        w_srcLoad, w_srcInc, w_dstLoad, w_dstInc;
  logic [AW:0] w_srcPtr, w_dstPtr, w_dstLoadVal;

  // Pointer counters hold src+i and dst+i for the byte currently in flight
  dpr_addr_step #(.AW(AW)) u_srcStep (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_srcLoad),
    .i_loadVal (src),
    .i_inc     (w_srcInc),
    .o_value   (w_srcPtr)
  );

  dpr_addr_step #(.AW(AW)) u_dstStep (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_dstLoad),
    .i_loadVal (w_dstLoadVal),
    .i_inc     (w_dstInc),
    .o_value   (w_dstPtr)
  );

`ifdef DPR_COPIER_FILL_EN
  logic [DW-1:0] r_pattern;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pattern <= '0;
    end else if (r_state == IDLE && start) begin
      r_pattern <= pattern;
    end
  end

  assign w_fillReq = fill;
  assign ram_d     = r_fill ? r_pattern : ram_q;
`else
  assign w_fillReq = 1'b0;
  assign ram_d     = ram_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_a     <= '0;
      r_left  <= '0;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
      r_we    <= w_weNext;
      r_a     <= w_aNext;
      r_left  <= w_leftNext;
      r_fill  <= w_fillNext;
    end
  end

  // Fill mode stays in WR with the write enable held, writing one byte per cycle
  always_comb begin
    w_stateNext  = r_state;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    w_weNext     = r_we;
    w_aNext      = r_a;
    w_leftNext   = r_left;
    w_fillNext   = r_fill;
    w_srcLoad    = 1'b0;
    w_srcInc     = 1'b0;
    w_dstLoad    = 1'b0;
    w_dstInc     = 1'b0;
    w_dstLoadVal = dst;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_doneNext = 1'b1;
          end else begin
            w_leftNext = len;
            w_busyNext = 1'b1;
            w_srcLoad  = 1'b1;
            w_dstLoad  = 1'b1;
            w_fillNext = w_fillReq;
            if (w_fillReq) begin
              w_aNext      = dst;
              w_weNext     = 1'b1;
              w_dstLoadVal = dst + ONE;
              w_stateNext  = WR;
            end else begin
              w_aNext     = src;
              w_weNext    = 1'b0;
              w_stateNext = RD;
            end
          end
        end
      end
      RD: begin
        if (stop) begin
          w_stateNext = IDLE;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
          w_weNext    = 1'b0;
        end else begin
          w_aNext     = w_dstPtr;
          w_weNext    = 1'b1;
          w_srcInc    = 1'b1;
          w_stateNext = WR;
        end
      end
      WR: begin
        w_leftNext = r_left - ONE;
        if (stop || r_left == ONE) begin
          w_stateNext = IDLE;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
          w_weNext    = 1'b0;
        end else if (r_fill) begin
          w_aNext  = w_dstPtr;
          w_weNext = 1'b1;
          w_dstInc = 1'b1;
        end else begin
          w_aNext     = w_srcPtr;
          w_weNext    = 1'b0;
          w_dstInc    = 1'b1;
          w_stateNext = RD;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_busyNext  = 1'b0;
        w_weNext    = 1'b0;
      end
    endcase
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign ram_we = r_we;
  assign ram_a  = r_a;

endmodule
